// File: rtl/tx_ramp_pkg.sv
// ---------------------------------------------------------------------------
// tx_ramp_pkg
// Shared definitions for the transmit envelope path. The DAC output
// formatter imports TX_DATA_WIDTH from here, so the sample width stays the
// same on both sides of the shaper.
//
// Contents:
//   TX_DATA_WIDTH          signed TX baseband sample width
//   TX_RAMP_BITS_DEFAULT   default log2 of the key-down/key-up ramp length
//   ST_IDLE .. ST_RAMP_DOWN  envelope state encoding
// ---------------------------------------------------------------------------
package tx_ramp_pkg;

    localparam int TX_DATA_WIDTH        = 27;
    localparam int TX_RAMP_BITS_DEFAULT = 10;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_ON        = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

endpackage

// File: rtl/tx_ramp_mult.sv
// ---------------------------------------------------------------------------
// tx_ramp_mult
// Registered signed-sample x unsigned-gain scaler with a floor (arithmetic)
// right shift by SHIFT bits. With gain = 2^SHIFT the output is bit-exact
// with the input; with gain = 0 it is zero. It is also intended for reuse
// by the TX drive-level scaler.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   sample_valid    data_in carries a new sample this cycle
//   force_zero      output zero for this sample regardless of gain
//   data_in         signed input sample, DATA_WIDTH bits
//   gain            unsigned gain, SHIFT+1 bits, 0 .. 2^SHIFT
//   data_out        signed scaled sample, held while sample_valid is low
//   data_out_valid  data_out was updated on the last edge
// ---------------------------------------------------------------------------
module tx_ramp_mult #(
    parameter int DATA_WIDTH = 27,
    parameter int SHIFT      = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_valid,
    input  logic                         force_zero,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic        [SHIFT:0]        gain,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid
);

    localparam int GAIN_BITS = SHIFT + 1;
    localparam int PROD_W    = DATA_WIDTH + GAIN_BITS;

    logic signed [PROD_W-1:0]     data_ext;
    logic signed [PROD_W-1:0]     gain_ext;
    logic signed [PROD_W-1:0]     product;
    logic signed [PROD_W-1:0]     shifted;
    logic signed [DATA_WIDTH-1:0] scaled;
    logic                         unused_shifted;

    // Both operands are widened to the full product width as signed values;
    // the gain gets zero-extension so it is always non-negative. The product
    // of a 27-bit sample and a gain of at most 2^SHIFT fits without overflow,
    // and after the arithmetic shift the result fits back in DATA_WIDTH bits.
    always_comb begin
        data_ext = {{GAIN_BITS{data_in[DATA_WIDTH-1]}}, data_in};
        gain_ext = {{DATA_WIDTH{1'b0}}, gain};
        product  = data_ext * gain_ext;
        shifted  = product >>> SHIFT;
        scaled   = shifted[DATA_WIDTH-1:0];
    end

    // The upper bits of the shifted product are only sign copies.
    assign unused_shifted = ^shifted[PROD_W-1:DATA_WIDTH];

    // Output register: update only on a valid sample, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= sample_valid;
            if (sample_valid) begin
                data_out <= force_zero ? '0 : scaled;
            end
        end
    end

endmodule

// File: rtl/tx_ramp_shaper.sv
// ---------------------------------------------------------------------------
// tx_ramp_shaper
// Transmit envelope shaper placed just upstream of the DAC output formatter.
// On key-down it ramps the gain linearly from 0 to FULL = 2^RAMP_BITS, on
// key-up it ramps back to 0, one gain step per valid sample, which keeps
// key clicks out of the spectrum. tx_out tells the formatter when to pass
// live data instead of mid-scale.
//
// Ports:
//   clk_in          sample-domain clock
//   reset_n         asynchronous active-low reset
//   tx_req          raw transmit request (key/PTT), synchronous to clk_in
//   data_in         signed TX sample
//   data_valid      data_in carries a new sample this cycle
//   data_out        signed shaped sample, one cycle after data_in
//   data_out_valid  data_out updated this cycle
//   tx_out          gated transmit enable, high while the envelope is active
//   ramp_busy       high while ramping up or down
// ---------------------------------------------------------------------------
module tx_ramp_shaper
    import tx_ramp_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH,
    parameter int RAMP_BITS  = TX_RAMP_BITS_DEFAULT
) (
    input  logic                         clk_in,
    input  logic                         reset_n,
    input  logic                         tx_req,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic                         tx_out,
    output logic                         ramp_busy
);

    localparam int              GAIN_W = RAMP_BITS + 1;
    localparam logic [GAIN_W-1:0] FULL = {1'b1, {RAMP_BITS{1'b0}}};

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [GAIN_W-1:0] gain;
    logic [GAIN_W-1:0] gain_nxt;

    // Envelope next-state and gain logic. The current sample is always
    // scaled by the pre-edge gain; stepping happens afterwards and only on
    // valid samples, so the ramp stalls with the stream. A reversal of
    // tx_req changes direction while keeping the gain, so the envelope
    // turns around without a step discontinuity.
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        case (state)
            ST_IDLE: begin
                if (tx_req) begin
                    state_nxt = ST_RAMP_UP;
                    gain_nxt  = '0;
                end
            end
            ST_RAMP_UP: begin
                if (!tx_req) begin
                    state_nxt = ST_RAMP_DOWN;
                end else if (data_valid) begin
                    if (gain == FULL) begin
                        state_nxt = ST_ON;
                    end else begin
                        gain_nxt = gain + 1'b1;
                        if (gain_nxt == FULL) begin
                            state_nxt = ST_ON;
                        end
                    end
                end
            end
            ST_ON: begin
                gain_nxt = FULL;
                if (!tx_req) begin
                    state_nxt = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (tx_req) begin
                    // Already at full gain there is nothing left to ramp.
                    state_nxt = (gain == FULL) ? ST_ON : ST_RAMP_UP;
                end else if (data_valid) begin
                    if (gain == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        gain_nxt = gain - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gain_nxt  = '0;
            end
        endcase
    end

    // State, gain and the two status flags. tx_out and ramp_busy are taken
    // from the next state so they change on the same edge as the state
    // itself: tx_out rises on the key-down edge and falls on the edge that
    // consumes the final zero-gain sample.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            gain      <= '0;
            tx_out    <= 1'b0;
            ramp_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            gain      <= gain_nxt;
            tx_out    <= (state_nxt != ST_IDLE);
            ramp_busy <= (state_nxt == ST_RAMP_UP) || (state_nxt == ST_RAMP_DOWN);
        end
    end

    tx_ramp_mult #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (RAMP_BITS)
    ) u_mult (
        .clk            (clk_in),
        .rst_n          (reset_n),
        .sample_valid   (data_valid),
        .force_zero     (state == ST_IDLE),
        .data_in        (data_in),
        .gain           (gain),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

endmodule

// File: tb/tb_tx_ramp_shaper.sv
// ---------------------------------------------------------------------------
// tb_tx_ramp_shaper
// Self-checking bench for tx_ramp_shaper with RAMP_BITS = 3 (FULL = 8).
// A behavioural envelope model (active flag, direction, integer gain) gives
// the expected outputs for every driven cycle.
// ---------------------------------------------------------------------------
module tb_tx_ramp_shaper;

    localparam int DW   = 27;
    localparam int RB   = 3;
    localparam int FULL = 1 << RB;

    logic                 clk_in;
    logic                 reset_n;
    logic                 tx_req;
    logic signed [DW-1:0] data_in;
    logic                 data_valid;
    logic signed [DW-1:0] data_out;
    logic                 data_out_valid;
    logic                 tx_out;
    logic                 ramp_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    bit m_active;
    bit m_rising;
    int m_gain;
    int m_out;
    bit m_valid;

    tx_ramp_shaper #(
        .DATA_WIDTH (DW),
        .RAMP_BITS  (RB)
    ) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .tx_req         (tx_req),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .tx_out         (tx_out),
        .ramp_busy      (ramp_busy)
    );

    // 100 MHz sample clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int sext27(input int raw);
        int v;
        v = raw & ((1 << DW) - 1);
        if (v >= (1 << (DW - 1))) v = v - (1 << DW);
        return v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_rising = 1'b0;
        m_gain   = 0;
        m_out    = 0;
        m_valid  = 1'b0;
    endtask

    // One sample period of the envelope: the sample uses the current gain,
    // then the envelope moves toward tx_req one step per valid sample.
    task automatic model_step(input bit req, input int din, input bit valid);
        if (valid) m_out = m_active ? floor_div(din * m_gain, FULL) : 0;
        m_valid = valid;
        if (!m_active) begin
            if (req) begin
                m_active = 1'b1;
                m_rising = 1'b1;
                m_gain   = 0;
            end
        end else if (m_rising) begin
            if (!req) m_rising = 1'b0;
            else if (valid && m_gain < FULL) m_gain = m_gain + 1;
        end else begin
            if (req) m_rising = 1'b1;
            else if (valid) begin
                if (m_gain == 0) m_active = 1'b0;
                else m_gain = m_gain - 1;
            end
        end
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_busy;
        exp_busy = m_active && !(m_rising && m_gain == FULL);
        check_output({tag, ".data_out"}, int'(data_out), m_out);
        check_output({tag, ".data_out_valid"}, int'(data_out_valid), int'(m_valid));
        check_output({tag, ".tx_out"}, int'(tx_out), int'(m_active));
        check_output({tag, ".ramp_busy"}, int'(ramp_busy), int'(exp_busy));
    endtask

    // Drive one cycle, advance the model with the pre-edge inputs, then
    // check the registered outputs 1 ns after the edge.
    task automatic apply_stimulus(input string tag, input bit req, input int din, input bit valid);
        tx_req     = req;
        data_in    = din[DW-1:0];
        data_valid = valid;
        model_step(req, din, valid);
        @(posedge clk_in);
        #1;
        check_all(tag);
    endtask

    initial begin
        int d;
        bit r;
        tx_req     = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        reset_n    = 1'b0;
        model_reset();
        #12;
        $display("[TB] reset state");
        check_all("reset");
        @(negedge clk_in);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus("idle", 1'b0, 1000, 1'b1);

        $display("[TB] ramp up, data_in=+800");
        for (int i = 0; i < 12; i++) apply_stimulus("ramp_up", 1'b1, 800, 1'b1);
        check_output("on_pass_through", int'(data_out), 800);

        $display("[TB] asynchronous reset while ON");
        #($urandom_range(1, 7));
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk_in);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus("post_reset", 1'b0, 555, 1'b1);

        $display("[TB] ramp down, data_in=-801");
        for (int i = 0; i < 10; i++) apply_stimulus("up_for_down", 1'b1, -801, 1'b1);
        for (int i = 0; i < 11; i++) apply_stimulus("ramp_down", 1'b0, -801, 1'b1);
        check_output("down_end_tx_out", int'(tx_out), 0);

        $display("[TB] reversal");
        for (int i = 0; i < 4; i++) apply_stimulus("rev_up", 1'b1, 800, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus("rev_down", 1'b0, 800, 1'b1);
        for (int i = 0; i < 10; i++) apply_stimulus("rev_resume", 1'b1, 800, 1'b1);

        $display("[TB] stall mid ramp");
        for (int i = 0; i < 11; i++) apply_stimulus("stall_down", 1'b0, 640, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus("stall_pre", 1'b1, 640, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus("stall", 1'b1, 12345, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus("stall_resume", 1'b1, 640, 1'b1);

        $display("[TB] extremes");
        apply_stimulus("ext_full_neg", 1'b1, -(1 << 26), 1'b1);
        check_output("ext_full_neg_exact", int'(data_out), -(1 << 26));
        apply_stimulus("ext_full_pos", 1'b1, (1 << 26) - 1, 1'b1);
        check_output("ext_full_pos_exact", int'(data_out), (1 << 26) - 1);
        for (int i = 0; i < 5; i++) apply_stimulus("ext_down", 1'b0, 0, 1'b1);
        apply_stimulus("ext_g4_neg", 1'b1, -(1 << 26), 1'b1);
        check_output("ext_g4_neg_value", int'(data_out), -(1 << 25));
        apply_stimulus("ext_g4_pos", 1'b1, (1 << 26) - 1, 1'b1);
        check_output("ext_g4_pos_value", int'(data_out), (1 << 25) - 1);

        $display("[TB] randomized traffic");
        r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) r = ~r;
            d = sext27(int'($urandom));
            apply_stimulus("random", r, d, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/tx_ramp_shaper.md
Name: tx_ramp_shaper

Overview:
- Transmit envelope shaper that sits directly upstream of the DAC output formatter.
- It takes the signed 27-bit TX baseband sample stream and a raw transmit request.
- It applies a linear gain ramp on key-down and key-up to suppress key clicks.
- It emits the shaped sample plus the gated tx signal that the DAC formatter uses to select between live data and mid-scale.

Parameters:
- DATA_WIDTH, 27, signed sample width in and out.
- RAMP_BITS, 10, log2 of ramp length in samples; full-scale gain FULL = 2^RAMP_BITS.

Ports:
- clk_in  input  1  sample-domain clock.
- reset_n  input  1  asynchronous active-low reset.
- tx_req  input  1  raw transmit request (key/PTT), synchronous to clk_in.
- data_in  input  DATA_WIDTH  signed TX sample.
- data_valid  input  1  data_in carries a new sample this cycle.
- data_out  output  DATA_WIDTH  signed shaped sample to the DAC formatter.
- data_out_valid  output  1  data_out updated this cycle.
- tx_out  output  1  gated transmit enable to the DAC formatter; high while any envelope is non-idle.
- ramp_busy  output  1  high in RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, gain=0.
  - data_out=0, data_out_valid=0, tx_out=0, ramp_busy=0.
  - Reset applied mid-ramp aborts the ramp immediately with no completion.
- Gain register: unsigned, RAMP_BITS+1 bits, range 0..FULL inclusive. It never wraps: increments stop at FULL and decrements stop at 0.
- Datapath, 1-cycle latency:
  - On a valid sample, data_out <= (data_in * gain) >>> RAMP_BITS.
  - The shift is arithmetic (floor); the product is held at DATA_WIDTH+RAMP_BITS+1 bits before the shift.
  - With gain=FULL the output is bit-exact data_in; with gain=0 the output is 0.
  - data_out_valid <= data_valid; data_out holds its value when data_valid=0.
  - In IDLE, data_out is forced to 0 on valid samples.
- FSM (state advances only as stated; gain steps only on data_valid=1 cycles, after the current gain has been used for that sample):
  - IDLE: tx_req=1 -> RAMP_UP, gain=0, tx_out<=1 in the same clock edge.
  - RAMP_UP, valid sample: output uses gain g, then gain<=g+1; if g+1==FULL -> ON. Output sequence from IDLE is 0,1,...,FULL-1 (FULL samples).
  - RAMP_UP with tx_req=0 -> RAMP_DOWN on the next edge, keeping the current gain (no step discontinuity).
  - ON: gain=FULL, straight pass-through. tx_req=0 -> RAMP_DOWN, gain unchanged.
  - RAMP_DOWN, valid sample: output uses gain g; if g==0 -> IDLE and tx_out<=0 on that edge, else gain<=g-1. From ON the output sequence is FULL,...,1,0 (FULL+1 samples).
  - RAMP_DOWN with tx_req=1 -> RAMP_UP on the next edge from the current gain.
- tx_req toggling on a data_valid cycle: the state change and the gain step for that sample use the pre-edge state; the sample is processed under the old state.
- tx_out = registered (state != IDLE).
  - It stays high through the final zero-gain sample, so the formatter never switches to mid-scale while the envelope is non-zero.
  - It drops on the edge that enters IDLE.
- ramp_busy is registered alongside state.
- No gain stepping occurs if data_valid stays low; the ramp stalls with the stream.

Decomposition:
- Shared TX package holds:
  - state encoding IDLE/RAMP_UP/ON/RAMP_DOWN;
  - TX_DATA_WIDTH=27, which the DAC formatter also uses;
  - default RAMP_BITS.
- One sub-module is natural: tx_ramp_mult, the registered signed×unsigned multiply with arithmetic shift, which is reusable for the TX drive-level scaler. The FSM and gain counter stay in the top.

Test Plan (RAMP_BITS=3, FULL=8, data_valid=1 every cycle unless stated):
- Reset: reset_n=0 asserted mid-ON at an arbitrary clock phase -> data_out=0, tx_out=0, ramp_busy=0 immediately; after release with tx_req=0, everything stays 0.
- Ramp up: data_in=+800 constant, tx_req 0->1 -> tx_out rises on the same edge; data_out sequence 0,100,200,...,700, then 800 held; ramp_busy high for exactly 8 samples.
- Ramp down: from ON with data_in=-801, tx_req 1->0 -> data_out -801,-701,-601,-501,-401,-301,-201,-101,0 (floor rounding); tx_out falls on the edge after the zero sample.
- Reversal: tx_req drops after the 3rd ramp-up sample (gain=3) -> RAMP_DOWN continues 3,2,1,0 with no jump; tx_req reasserted at gain=1 -> ramp-up resumes 1,2,... .
- Stall: data_valid=0 for 5 cycles mid-RAMP_UP -> gain frozen, data_out held, data_out_valid=0; the ramp resumes at the same gain.
- Extremes: data_in=-2^26 and 2^26-1 at gain=FULL -> bit-exact output; at gain=4 -> -2^25 and 2^25-1 respectively; no overflow.
